// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - D-stage hazard scoreboard: stall, forward selects, mult/div interlock.
// Optional mult/div busy interlock enabled by defining HAZARD_MD_STALL_EN.
module hazard_scoreboard #(
  parameter int STAGES      = 3,
  parameter int REG_AW      = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  localparam int FW         = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              d_valid,
  input  logic [TW-1:0]     d_tuse1,
  input  logic [TW-1:0]     d_tuse2,
  input  logic [REG_AW-1:0] d_ra1,
  input  logic [REG_AW-1:0] d_ra2,
  input  logic [TW-1:0]     d_tnew,
  input  logic [REG_AW-1:0] d_wa,
  input  logic              d_md_use,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              flush,
  output logic              stall,
  output logic [FW-1:0]     fwd_sel1,
  output logic [FW-1:0]     fwd_sel2,
  output logic              md_busy
);

  logic [REG_AW-1:0] wa_q   [1:STAGES];
  logic [TW-1:0]     tnew_q [1:STAGES];

  logic              found1, found2, hazard1, hazard2, md_hazard, accept;
  logic [FW-1:0]     k1, k2;
  logic [TW-1:0]     t1, t2;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - TW'(1);
  endfunction

  // Scan farthest to nearest so the lowest-index match is the one that sticks.
  always_comb begin
    found1 = 1'b0;
    found2 = 1'b0;
    k1     = '0;
    k2     = '0;
    t1     = '0;
    t2     = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (wa_q[k] != '0 && wa_q[k] == d_ra1) begin
        found1 = 1'b1;
        k1     = FW'(k);
        t1     = tnew_q[k];
      end
      if (wa_q[k] != '0 && wa_q[k] == d_ra2) begin
        found2 = 1'b1;
        k2     = FW'(k);
        t2     = tnew_q[k];
      end
    end
  end

  assign hazard1  = d_valid && found1 && (t1 > d_tuse1);
  assign hazard2  = d_valid && found2 && (t2 > d_tuse2);
  assign fwd_sel1 = (found1 && t1 == '0) ? k1 : '0;
  assign fwd_sel2 = (found2 && t2 == '0) ? k2 : '0;
  assign stall    = hazard1 | hazard2 | md_hazard;
  assign accept   = d_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 1; k <= STAGES; k++) begin
        wa_q[k]   <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        wa_q[1]   <= d_wa;
        tnew_q[1] <= dec_sat(d_tnew);
      end else begin
        wa_q[1]   <= '0;
        tnew_q[1] <= '0;
      end
      for (int k = 1; k < STAGES; k++) begin
        wa_q[k+1]   <= wa_q[k];
        tnew_q[k+1] <= dec_sat(tnew_q[k]);
      end
    end
  end

`ifdef HAZARD_MD_STALL_EN
  localparam int CW = $clog2(DIV_CYCLES + 1);
  logic [CW-1:0] md_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else if (accept && d_md_start) begin
      md_cnt <= d_md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  assign md_busy   = (md_cnt != '0);
  assign md_hazard = d_valid & d_md_use & md_busy;
`else
  logic unused_md;
  assign unused_md = ^{d_md_use, d_md_start, d_md_div, MULT_CYCLES[0], DIV_CYCLES[0]};
  assign md_busy   = 1'b0;
  assign md_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard (directed vectors).
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       d_valid, d_md_use, d_md_start, d_md_div, flush;
  logic [1:0] d_tuse1, d_tuse2, d_tnew;
  logic [4:0] d_ra1, d_ra2, d_wa;
  logic       stall, md_busy;
  logic [1:0] fwd_sel1, fwd_sel2;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .d_valid(d_valid),
    .d_tuse1(d_tuse1), .d_tuse2(d_tuse2), .d_ra1(d_ra1), .d_ra2(d_ra2),
    .d_tnew(d_tnew), .d_wa(d_wa), .d_md_use(d_md_use), .d_md_start(d_md_start),
    .d_md_div(d_md_div), .flush(flush), .stall(stall),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .md_busy(md_busy)
  );

  function automatic logic [5:0] mk(input logic s, input logic [1:0] f1,
                                    input logic [1:0] f2, input logic md);
    return {s, f1, f2, md};
  endfunction

  // Monitor: compares DUT outputs mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [5:0] e;
      logic [5:0] a;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {stall, fwd_sel1, fwd_sel2, md_busy};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got stall=%0b fwd1=%0d fwd2=%0d md_busy=%0b, expected stall=%0b fwd1=%0d fwd2=%0d md_busy=%0b",
                 n, a[5], a[4:3], a[2:1], a[0], e[5], e[4:3], e[2:1], e[0]);
      end
    end
  end

  task automatic cyc(input logic v, input logic [4:0] ra1, input logic [1:0] tu1,
                     input logic [4:0] ra2, input logic [1:0] tu2,
                     input logic [4:0] wa, input logic [1:0] tn,
                     input logic mu, input logic ms, input logic mdv, input logic fl,
                     input logic chk, input logic [5:0] e, input string nm);
    d_valid = v; d_ra1 = ra1; d_tuse1 = tu1; d_ra2 = ra2; d_tuse2 = tu2;
    d_wa = wa; d_tnew = tn; d_md_use = mu; d_md_start = ms; d_md_div = mdv; flush = fl;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'd0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "reset_state");

    // Fill with $5 writers (and a div), then reset mid-operation.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 5, 3, 0, 1, 1, 0, 0, 6'd0, "");
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "reset_discard");
    idle(3);

    // Load-use: lw $1 then addu $2,$1,$3; then check the bubble in M.
    cyc(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "lw_issue");
    cyc(1, 1, 1, 3, 1, 2, 2, 0, 0, 0, 0, 1, mk(1, 0, 0, 0), "load_use_stall");
    cyc(1, 1, 1, 3, 1, 2, 2, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "load_use_release");
    cyc(1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, mk(1, 3, 0, 0), "bubble_fwd_w");
    cyc(1, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 2, 0), "bubble_fwd_m");
    idle(3);

    // Branch after ALU.
    cyc(1, 0, 0, 0, 0, 4, 2, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "addu4_issue");
    cyc(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(1, 0, 0, 0), "beq_stall");
    cyc(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 2, 0, 0), "beq_fwd_m");
    idle(3);

    // $0 writer never matches.
    cyc(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "zero_writer");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "zero_read1");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "zero_read2");
    idle(3);

    // Priority and Tnew saturation as $5 drains to W.
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "lui5_issue");
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "ori5_issue");
    cyc(1, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 1, mk(0, 1, 1, 0), "priority_e");
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 2, 0, 0), "sat_m");
    cyc(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 3, 0, 0), "sat_w");
    idle(3);

    // Nearer busy writer overrides a farther ready one.
    cyc(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "w6_ready");
    cyc(1, 0, 0, 0, 0, 6, 3, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "w6_busy");
    cyc(1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 1, mk(1, 0, 0, 0), "nearest_stall");
    idle(3);

    // Flushed writer becomes a bubble.
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 1, mk(0, 0, 0, 0), "flush_issue");
    cyc(1, 7, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "flush_bubble");
    idle(3);

`ifdef HAZARD_MD_STALL_EN
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, mk(0, 0, 0, 0), "div_issue");
    for (int i = 0; i < 10; i++)
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, mk(1, 0, 0, 1), "mflo_stall");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, mk(0, 0, 0, 0), "mflo_release");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, mk(0, 0, 0, 0), "mult_issue");
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 1), "mult_busy");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0), "mult_done");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, mk(0, 0, 0, 0), "mult_flush");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, mk(0, 0, 0, 0), "mult_flush_idle");
`else
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, mk(0, 0, 0, 0), "div_issue_off");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, mk(0, 0, 0, 0), "mflo_no_stall");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, mk(0, 0, 0, 0), "mflo_no_stall2");
`endif

    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline hazard scoreboard for the MIPS core. It sits beside the D stage and consumes the per-instruction Tuse/Tnew/register-address tuples produced by the decode-side AT controller. It tracks every in-flight writer across STAGES downstream stages with a self-decrementing Tnew, and emits the D-stage stall, the D-stage forward selects and a multi-cycle mult/div busy interlock.

## Interface

Parameters:
- STAGES, 3, downstream stages tracked (1=E, 2=M, 3=W, …)
- REG_AW, 5, register address width
- TW, 2, Tuse/Tnew width
- MULT_CYCLES, 5, mult/multu busy cycles
- DIV_CYCLES, 10, div/divu busy cycles

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - clk, input, 1, clock
  - reset_n, input, 1, synchronous active-low reset
- d_valid, input, 1, D-stage instruction valid
- d_tuse1, d_tuse2, input, TW, Tuse of read ports
- d_ra1, d_ra2, input, REG_AW, read addresses (0 = unused)
- d_tnew, input, TW, D-relative Tnew of the writer
- d_wa, input, REG_AW, write address (0 = none)
- d_md_use, input, 1, D instr touches HI/LO
- d_md_start, input, 1, D instr is mult/div class
- d_md_div, input, 1, qualifies d_md_start as div/divu
- flush, input, 1, force a bubble into E this cycle
- stall, output, 1, hold PC/D, insert bubble into E
- fwd_sel1, fwd_sel2, output, FW=$clog2(STAGES+1), 0 = register file, k = forward from stage k
- md_busy, output, 1, mult/div unit occupied

## Operation

- Table: STAGES entries {wa, tnew}; entry 1 = E.
- Advance every cycle, no downstream stalls:
  - entry k+1 ← {wa_k, sat0(tnew_k − 1)}
  - entry 1 ← {d_wa, sat0(d_tnew − 1)} when d_valid & !stall & !flush; otherwise bubble {0, 0}.
- Match on port i: entry with wa = d_ra_i and wa ≠ 0. The nearest (lowest k) match wins; a farther match is ignored.
- Stall:
  - port i hazard = d_valid & d_ra_i ≠ 0 & nearest match has tnew > d_tuse_i.
  - stall = hazard1 | hazard2 | md_hazard.
- Forward: fwd_sel_i = k when the nearest match k has tnew = 0, else 0. Evaluated irrespective of stall.
- Register 0 never matches, never stalls, never forwards.
- MD counter, width $clog2(DIV_CYCLES+1):
  - On accepted issue (d_valid & d_md_start & !stall & !flush): load DIV_CYCLES if d_md_div, else MULT_CYCLES.
  - Otherwise decrement, saturating at 0.
  - md_busy = counter ≠ 0.
  - md_hazard = d_valid & d_md_use & md_busy.
- flush with stall: bubble still enters E, and the counter does not load.

## Timing

- stall, fwd_sel and md_hazard are combinational from table state plus D inputs, with zero latency.
- Table and counter update on the rising clk edge.
- Reset, sampled at the clk edge while reset_n = 0:
  - all entries {0, 0}, counter 0.
  - With idle inputs this gives stall = 0, fwd_sel1/2 = 0, md_busy = 0 from the next cycle.
- Reset mid-operation discards all in-flight writers and any mult/div countdown.
- An md instr issued at edge n sees md_busy = 1 from cycle n+1 for exactly MULT_CYCLES / DIV_CYCLES cycles.
- Tnew saturation: a W-stage entry reaching 0 stays 0 until overwritten.

## Configuration

- HAZARD_MD_STALL_EN defined:
  - MD counter, md_busy and md_hazard as above.
- Undefined:
  - no counter; md_busy tied 0; md_hazard = 0.
  - d_md_use, d_md_start and d_md_div are ignored.
  - Used when mult/div is single-cycle or self-interlocked.

## Test plan

- Reset: drive reset_n = 0 for 2 cycles after filling the table with wa = 5, tnew = 3 → next cycle a reader of $5 with tuse 0 gives stall = 0, fwd_sel = 0, md_busy = 0.
- Load-use: lw $1 (d_tnew 3) then addu $2,$1,$3 (tuse1 1) → stall = 1 for exactly 1 cycle, then 0. Bubble inserted into E.
- Branch after ALU: addu $4 (d_tnew 2) then beq $4,$0 (tuse 0) → stall 1 cycle, then fwd_sel1 = 2, stall = 0.
- $0 writer: addu $0 then beq $0,$0 → stall = 0 and fwd_sel = 0 throughout.
- Priority: ori $5 (d_tnew 1) in E and lui $5 in M, both tnew 0 → fwd_sel1 = 1.
- MD (macro on), case 1: div then mflo (d_md_use) → md_busy = 1 for 10 cycles, stall = 1 for those 10 cycles, stall = 0 on cycle 11.
- MD (macro on), case 2: mult with flush asserted → counter stays 0.
